// File: rtl/compute_initiator_pkg.sv
// Shared types and default constants for the compute initiator.
package compute_initiator_pkg;

  localparam int unsigned W_DEF   = 8;
  localparam int unsigned TMO_DEF = 16;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/compute_initiator_wait_counter.sv
// Cycle counter for the WAIT state; term flags the last allowed cycle (TMO-1).
import compute_initiator_pkg::*;

module wait_counter #(
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic term
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TMO - 1);

  logic [CNT_W-1:0] count;

  // Clear has priority over enable; the counter is never expected to wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign term = (count == TERM_VAL);

endmodule

// File: rtl/compute_initiator.sv
// Accepts operand pairs, pulses start to the compute side, waits for done
// (with timeout), and holds the captured result until downstream takes it.
import compute_initiator_pkg::*;

module compute_initiator #(
  parameter int unsigned W   = W_DEF,
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           start,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  input  logic           done,
  input  logic [2*W-1:0] res_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_data,
  output logic           timeout_err
);

  state_t state;
  state_t state_next;
  logic   latch_in;
  logic   capture;
  logic   set_tmo;
  logic   cnt_clear;
  logic   cnt_en;
  logic   cnt_term;

  wait_counter #(.TMO(TMO)) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .term   (cnt_term)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control; done beats the timeout in the same cycle.
  always_comb begin
    state_next = state;
    latch_in   = 1'b0;
    capture    = 1'b0;
    set_tmo    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          latch_in   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_clear  = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (done) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end else if (cnt_term) begin
          set_tmo    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand, result and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a        <= '0;
      op_b        <= '0;
      out_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (latch_in) begin
        op_a <= in_a;
        op_b <= in_b;
      end
      if (capture) begin
        out_data <= res_in;
      end
      if (set_tmo) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Handshake outputs decoded straight from the state register.
  assign in_ready  = (state == ST_IDLE);
  assign start     = (state == ST_ISSUE);
  assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_compute_initiator.sv
// Directed self-checking bench for compute_initiator (W=8, TMO=16).
module tb_compute_initiator;

  localparam int unsigned W   = 8;
  localparam int unsigned TMO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           done;
  logic [2*W-1:0] res_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_data;
  logic           timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  int             start_cnt = 0;
  int             ov_cnt    = 0;
  logic [15:0]    res_log[$];

  compute_initiator #(.W(W), .TMO(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .done        (done),
    .res_in      (res_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Observe start pulses, out_valid cycles and accepted results mid-cycle.
  always @(negedge clk) begin
    if (start) start_cnt++;
    if (out_valid) ov_cnt++;
    if (out_valid && out_ready) res_log.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0;
    int v0;
    int q0;
    logic [15:0] exp_res[3];
    exp_res[0] = 16'hA001;
    exp_res[1] = 16'hA002;
    exp_res[2] = 16'hA003;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    done = 1'b0; res_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_start", 32'(start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_op_b", 32'(op_b), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk) rst = 1'b0;

    // done pulse while IDLE must be ignored
    done = 1'b1; res_in = 16'hDEAD; tick; done = 1'b0; res_in = '0;
    check("idle_done_in_ready", 32'(in_ready), 32'd1);
    check("idle_done_out_valid", 32'(out_valid), 32'd0);
    check("idle_done_out_data", 32'(out_data), 32'd0);

    // Basic job: done two cycles after start
    s0 = start_cnt;
    in_valid = 1'b1; in_a = 8'h0C; in_b = 8'h05; tick; in_valid = 1'b0;
    check("a_start", 32'(start), 32'd1);
    check("a_in_ready", 32'(in_ready), 32'd0);
    check("a_op_a", 32'(op_a), 32'h0C);
    check("a_op_b", 32'(op_b), 32'h05);
    tick;
    check("a_start_one_cycle", 32'(start), 32'd0);
    tick;
    done = 1'b1; res_in = 16'h003C; tick; done = 1'b0; res_in = '0;
    check("a_out_valid", 32'(out_valid), 32'd1);
    check("a_out_data", 32'(out_data), 32'h003C);
    repeat (2) begin
      tick;
      check("a_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1; tick; out_ready = 1'b0;
    check("a_release_valid", 32'(out_valid), 32'd0);
    check("a_release_in_ready", 32'(in_ready), 32'd1);
    check("a_start_count", 32'(start_cnt - s0), 32'd1);

    // done in the last allowed WAIT cycle (counter = TMO-1) wins over timeout
    in_valid = 1'b1; in_a = 8'h33; in_b = 8'h44; tick; in_valid = 1'b0;
    repeat (TMO) tick;
    check("b_still_wait_valid", 32'(out_valid), 32'd0);
    check("b_still_wait_tmo", 32'(timeout_err), 32'd0);
    done = 1'b1; res_in = 16'hBEEF; tick; done = 1'b0; res_in = '0;
    check("b_out_valid", 32'(out_valid), 32'd1);
    check("b_out_data", 32'(out_data), 32'hBEEF);
    check("b_tmo_clear", 32'(timeout_err), 32'd0);
    out_ready = 1'b1; tick; out_ready = 1'b0;
    check("b_idle", 32'(in_ready), 32'd1);

    // Best-case latency, then 10 stalled HOLD cycles with noise on inputs
    in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; tick; in_valid = 1'b0;
    tick;
    done = 1'b1; res_in = 16'h1234; tick; done = 1'b0;
    check("c_latency3_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 8'(i + 100);
      in_b = 8'(i + 200);
      done = (i == 4);
      res_in = 16'hFFFF;
      tick;
      check("c_hold_data", 32'(out_data), 32'h1234);
      check("c_hold_in_ready", 32'(in_ready), 32'd0);
      check("c_hold_op_a", 32'(op_a), 32'h11);
      check("c_hold_op_b", 32'(op_b), 32'h22);
      check("c_hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; done = 1'b0; res_in = '0;
    out_ready = 1'b1; tick; out_ready = 1'b0;
    check("c_idle", 32'(in_ready), 32'd1);
    check("c_op_a_kept", 32'(op_a), 32'h11);

    // Timeout: flag rises on the edge ending the 16th WAIT cycle after start
    v0 = ov_cnt; s0 = start_cnt;
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h02; tick; in_valid = 1'b0;
    check("d_start", 32'(start), 32'd1);
    repeat (TMO) tick;
    check("d_tmo_not_early", 32'(timeout_err), 32'd0);
    check("d_still_wait", 32'(in_ready), 32'd0);
    tick;
    check("d_tmo_set", 32'(timeout_err), 32'd1);
    check("d_back_idle", 32'(in_ready), 32'd1);
    check("d_out_valid", 32'(out_valid), 32'd0);
    check("d_out_data_kept", 32'(out_data), 32'h1234);
    check("d_no_valid_seen", 32'(ov_cnt - v0), 32'd0);
    check("d_start_count", 32'(start_cnt - s0), 32'd1);

    // Sticky error survives a normal job
    in_valid = 1'b1; in_a = 8'h05; in_b = 8'h06; tick; in_valid = 1'b0;
    tick;
    done = 1'b1; res_in = 16'h0030; tick; done = 1'b0; res_in = '0;
    check("e_out_data", 32'(out_data), 32'h0030);
    check("e_tmo_sticky", 32'(timeout_err), 32'd1);
    out_ready = 1'b1; tick; out_ready = 1'b0;

    // Asynchronous reset in the middle of WAIT
    in_valid = 1'b1; in_a = 8'h77; in_b = 8'h88; tick; in_valid = 1'b0;
    tick; tick;
    #2 rst = 1'b1;
    #1;
    check("f_in_ready", 32'(in_ready), 32'd1);
    check("f_start", 32'(start), 32'd0);
    check("f_out_valid", 32'(out_valid), 32'd0);
    check("f_op_a", 32'(op_a), 32'd0);
    check("f_op_b", 32'(op_b), 32'd0);
    check("f_out_data", 32'(out_data), 32'd0);
    check("f_tmo", 32'(timeout_err), 32'd0);
    @(negedge clk) rst = 1'b0;
    in_valid = 1'b1; in_a = 8'h09; in_b = 8'h03; tick; in_valid = 1'b0;
    check("f_first_accept", 32'(start), 32'd1);
    check("f_op_a_new", 32'(op_a), 32'h09);
    tick;
    done = 1'b1; res_in = 16'h001B; tick; done = 1'b0; res_in = '0;
    check("f_out_valid_after", 32'(out_valid), 32'd1);
    check("f_out_data_after", 32'(out_data), 32'h001B);
    out_ready = 1'b1; tick; out_ready = 1'b0;
    check("f_idle_after", 32'(in_ready), 32'd1);

    // Three jobs back-to-back with out_ready held high
    s0 = start_cnt; q0 = res_log.size();
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_a = 8'(j + 1); in_b = 8'(j + 2); tick; in_valid = 1'b0;
      check("g_start", 32'(start), 32'd1);
      tick;
      done = 1'b1; res_in = exp_res[j]; tick; done = 1'b0; res_in = '0;
      check("g_out_valid", 32'(out_valid), 32'd1);
      check("g_out_data", 32'(out_data), 32'(exp_res[j]));
      tick;
      check("g_idle_no_bubble", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;
    tick;
    check("g_start_count", 32'(start_cnt - s0), 32'd3);
    check("g_result_count", 32'(res_log.size() - q0), 32'd3);
    for (int j = 0; j < 3; j++) begin
      if (q0 + j < res_log.size())
        check("g_result_order", 32'(res_log[q0 + j]), 32'(exp_res[j]));
      else
        check("g_result_missing", 32'd0, 32'(exp_res[j]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
